hs32_mem_resp: RTL and testbench

//   Memory-side responder for the CPU memory handshake (req/rw/addr/dtw -> rdy/dtr).
//   Two initiator ports share one internal word RAM: the fetch port (read-only) and
//   the exec port (read/write). Round-robin arbitration and programmable wait states.
//   The block sits between the fetch/exec units and on-chip block RAM.

---
 rtl/hs32_mem_resp_if.sv | 25 ++
 rtl/hs32_mem_resp.sv | 144 ++++++++++++++
 tb/tb_hs32_mem_resp.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs32_mem_resp_if.sv
// Memory handshake bundle between the fetch/exec initiators and the responder.
// The fetch port is read-only; the exec port reads and writes.
interface hs32_mem_resp_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic [31:0] f_dtr;
  logic        f_rdy;
  logic        x_req;
  logic        x_rw;
  logic [31:0] x_addr;
  logic [31:0] x_dtw;
  logic [31:0] x_dtr;
  logic        x_rdy;
  logic        bus_err;

  modport master (
    output f_req, f_addr, x_req, x_rw, x_addr, x_dtw,
    input  f_dtr, f_rdy, x_dtr, x_rdy, bus_err
  );

  modport slave (
    input  f_req, f_addr, x_req, x_rw, x_addr, x_dtw,
    output f_dtr, f_rdy, x_dtr, x_rdy, bus_err
  );
endinterface

// File: rtl/hs32_mem_resp.sv
// Memory-side responder: two initiators (fetch, exec) share one word RAM.
// Round-robin arbitration, WAIT programmable wait cycles, registered rdy pulse.
module hs32_mem_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 1
) (
  input  logic           clk,
  input  logic           reset,
  hs32_mem_resp_if.slave bus
);
  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);
  localparam bit         HAS_WAIT = (WAIT > 0);

  if (WAIT < 0 || WAIT > 15) begin : g_bad_wait
    $error("hs32_mem_resp: WAIT must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            last_q, last_d;   // last completed grant: 0 = fetch, 1 = exec
  logic            port_q, port_d;   // granted port: 0 = fetch, 1 = exec
  logic            rw_q, rw_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     dtw_q, dtw_d;

  logic            go_done;          // entering DONE on this edge
  logic            complete;         // DONE cycle with the granted req still held
  logic            gnt_port;
  logic [31:0]     gnt_addr;
  logic            req_g;
  logic [31:0]     rd_word;

  logic            f_rdy_q, x_rdy_q, err_out_q;
  logic [31:0]     f_dtr_q, x_dtr_q;

  logic [31:0]     mem [DEPTH];

  assign bus.f_rdy   = f_rdy_q;
  assign bus.x_rdy   = x_rdy_q;
  assign bus.bus_err = err_out_q;
  assign bus.f_dtr   = f_dtr_q;
  assign bus.x_dtr   = x_dtr_q;

  // Errored reads return zero; otherwise the word being latched for DONE.
  assign rd_word = err_d ? 32'h0 : mem[idx_d];

  // Arbitration, wait counting and abort detection; latch the grant in IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    port_d   = port_q;
    rw_d     = rw_q;
    err_d    = err_q;
    idx_d    = idx_q;
    dtw_d    = dtw_q;
    go_done  = 1'b0;
    complete = 1'b0;
    gnt_port = (bus.f_req && bus.x_req) ? ~last_q : bus.x_req;
    gnt_addr = gnt_port ? bus.x_addr : bus.f_addr;
    req_g    = port_q ? bus.x_req : bus.f_req;
    unique case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.x_req) begin
          port_d  = gnt_port;
          rw_d    = gnt_port & bus.x_rw;   // fetch grants always read
          idx_d   = gnt_addr[AW+1:2];
          err_d   = (gnt_addr[1:0] != 2'b00) || (gnt_addr[31:AW+2] != '0);
          dtw_d   = bus.x_dtw;
          cnt_d   = WAIT_CNT;
          state_d = HAS_WAIT ? S_WAIT : S_DONE;
          go_done = !HAS_WAIT;
        end
      end
      S_WAIT: begin
        if (!req_g) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        // Any request seen here is ignored; re-arbitration happens in IDLE.
        state_d  = S_IDLE;
        complete = req_g;
        if (req_g) begin
          last_d = port_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and registered outputs; rdy/dtr/bus_err are set on entry to DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b0;
      f_rdy_q   <= 1'b0;
      x_rdy_q   <= 1'b0;
      err_out_q <= 1'b0;
      f_dtr_q   <= 32'h0;
      x_dtr_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      f_rdy_q   <= go_done && !port_d;
      x_rdy_q   <= go_done && port_d;
      err_out_q <= go_done && err_d;
      if (go_done && !rw_d) begin
        if (port_d) begin
          x_dtr_q <= rd_word;
        end else begin
          f_dtr_q <= rd_word;
        end
      end
    end
  end

  // Latched request fields; only meaningful while a grant is outstanding.
  always_ff @(posedge clk) begin
    port_q <= port_d;
    rw_q   <= rw_d;
    err_q  <= err_d;
    idx_q  <= idx_d;
    dtw_q  <= dtw_d;
  end

  // RAM write at the end of a completed, in-range exec write; suppressed by reset.
  always_ff @(posedge clk) begin
    if (state_q == S_DONE && complete && rw_q && !err_q && !reset) begin
      mem[idx_q] <= dtw_q;
    end
  end
endmodule

// File: tb/tb_hs32_mem_resp.sv
// Scoreboard bench for hs32_mem_resp: drivers push expected responses computed
// from a word-array reference model; a negedge monitor pops and compares.
module tb_hs32_mem_resp;
  localparam int AW = 10;
  localparam int W  = 1;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  logic rst_seen = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  resp_t f_q[$];
  resp_t x_q[$];
  bit    order[$];

  logic [31:0] mdl_mem [0:(1<<AW)-1];
  logic [31:0] f_hold_mdl = 32'h0;
  logic [31:0] x_hold_mdl = 32'h0;
  logic [31:0] f_hold_mon = 32'h0;
  logic [31:0] x_hold_mon = 32'h0;
  resp_t       mon_e;

  hs32_mem_resp_if bus ();

  hs32_mem_resp #(.AW(AW), .WAIT(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a >> (AW + 2)) != 0);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    return (a >> 2) % (1 << AW);
  endfunction

  function automatic resp_t model_x(input logic rw, input logic [31:0] a, input logic [31:0] d);
    resp_t r;
    r.err = addr_bad(a);
    if (rw) begin
      if (!r.err) mdl_mem[word_of(a)] = d;
      r.data = x_hold_mdl;
    end else begin
      r.data = r.err ? 32'h0 : mdl_mem[word_of(a)];
      x_hold_mdl = r.data;
    end
    return r;
  endfunction

  function automatic resp_t model_f(input logic [31:0] a);
    resp_t r;
    r.err  = addr_bad(a);
    r.data = r.err ? 32'h0 : mdl_mem[word_of(a)];
    f_hold_mdl = r.data;
    return r;
  endfunction

  // Monitor: pops expectations on each rdy, otherwise checks dtr hold and idle bus_err.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_f_rdy", {31'h0, bus.f_rdy}, 32'h0);
      chk("rst_x_rdy", {31'h0, bus.x_rdy}, 32'h0);
      chk("rst_bus_err", {31'h0, bus.bus_err}, 32'h0);
      chk("rst_f_dtr", bus.f_dtr, 32'h0);
      chk("rst_x_dtr", bus.x_dtr, 32'h0);
      f_hold_mon = 32'h0;
      x_hold_mon = 32'h0;
    end else begin
      chk("rdy_exclusive", {31'h0, bus.f_rdy & bus.x_rdy}, 32'h0);
      if (bus.f_rdy) begin
        chk("f_rdy_expected", {31'h0, f_q.size() != 0}, 32'h1);
        if (f_q.size() != 0) begin
          mon_e = f_q.pop_front();
          chk("f_dtr", bus.f_dtr, mon_e.data);
          chk("f_bus_err", {31'h0, bus.bus_err}, {31'h0, mon_e.err});
          f_hold_mon = mon_e.data;
        end
        order.push_back(1'b0);
      end else begin
        chk("f_dtr_hold", bus.f_dtr, f_hold_mon);
      end
      if (bus.x_rdy) begin
        chk("x_rdy_expected", {31'h0, x_q.size() != 0}, 32'h1);
        if (x_q.size() != 0) begin
          mon_e = x_q.pop_front();
          chk("x_dtr", bus.x_dtr, mon_e.data);
          chk("x_bus_err", {31'h0, bus.bus_err}, {31'h0, mon_e.err});
          x_hold_mon = mon_e.data;
        end
        order.push_back(1'b1);
      end else begin
        chk("x_dtr_hold", bus.x_dtr, x_hold_mon);
      end
      if (!bus.f_rdy && !bus.x_rdy) chk("bus_err_idle", {31'h0, bus.bus_err}, 32'h0);
    end
  end

  task automatic x_xfer(input logic rw, input logic [31:0] a, input logic [31:0] d, input bit lat);
    int c0;
    bit got;
    x_q.push_back(model_x(rw, a, d));
    bus.x_req  = 1'b1;
    bus.x_rw   = rw;
    bus.x_addr = a;
    bus.x_dtw  = d;
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.x_rdy) got = 1'b1;
    end
    chk("x_done", {31'h0, got}, 32'h1);
    if (got && lat) chk("x_latency", 32'(cyc - c0), 32'(1 + W));
    @(posedge clk); #1;
    bus.x_req = 1'b0;
  endtask

  task automatic f_xfer(input logic [31:0] a, input bit lat);
    int c0;
    bit got;
    f_q.push_back(model_f(a));
    bus.f_req  = 1'b1;
    bus.f_addr = a;
    c0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.f_rdy) got = 1'b1;
    end
    chk("f_done", {31'h0, got}, 32'h1);
    if (got && lat) chk("f_latency", 32'(cyc - c0), 32'(1 + W));
    @(posedge clk); #1;
    bus.f_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b1;
    bus.f_req = 1'b0;
    bus.x_req = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b0;
    f_hold_mdl = 32'h0;
    x_hold_mdl = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_ord [4];
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.f_req = 1'b0; bus.f_addr = 32'h0;
    bus.x_req = 1'b0; bus.x_rw = 1'b0; bus.x_addr = 32'h0; bus.x_dtw = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // Write then read back one word; latency and hold of x_dtr.
    x_xfer(1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    x_xfer(1'b0, 32'h10, 32'h0, 1'b1);
    idle(4);

    // Preload words 0..15 with random data.
    for (int i = 0; i < 16; i++) x_xfer(1'b1, 32'(i * 4), $urandom, 1'b1);
    idle(2);

    // Back-to-back fetch reads: period W+2.
    f_xfer(32'h0, 1'b1);
    f_xfer(32'h4, 1'b1);
    f_xfer(32'h8, 1'b1);
    idle(2);

    // Simultaneous requests from reset (last grant = fetch): exec, fetch, exec, fetch.
    do_reset();
    order.delete();
    fork
      begin f_xfer(32'h0, 1'b0); f_xfer(32'h4, 1'b0); end
      begin x_xfer(1'b0, 32'h20, 32'h0, 1'b0); x_xfer(1'b0, 32'h24, 32'h0, 1'b0); end
    join
    chk("rr_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk($sformatf("rr_grant%0d", i), {31'h0, order[i]}, {31'h0, exp_ord[i]});
    idle(2);

    // Misaligned / out-of-range accesses.
    x_xfer(1'b0, 32'h6, 32'h0, 1'b1);
    x_xfer(1'b1, 32'h1 << (AW + 2), 32'hA5A55A5A, 1'b1);
    x_xfer(1'b0, 32'h0, 32'h0, 1'b1);
    f_xfer(32'h2, 1'b1);
    f_xfer(32'h80000000, 1'b1);
    f_xfer(32'h0, 1'b1);
    idle(2);

    // Exec write aborted in WAIT; the next fetch must be served from IDLE.
    bus.x_req = 1'b1; bus.x_rw = 1'b1; bus.x_addr = 32'h14; bus.x_dtw = 32'hBAD0BAD0;
    idle(1);
    bus.x_req = 1'b0;
    idle(1);
    f_xfer(32'h14, 1'b1);
    idle(2);

    // Reset during WAIT of a write: outputs cleared, write not performed.
    bus.x_req = 1'b1; bus.x_rw = 1'b1; bus.x_addr = 32'h18; bus.x_dtw = 32'h12345678;
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0; bus.x_req = 1'b0;
    f_hold_mdl = 32'h0; x_hold_mdl = 32'h0;
    x_xfer(1'b0, 32'h18, 32'h0, 1'b1);
    idle(2);

    // Random concurrent traffic: fetch reads words 0..7, exec uses words 8..15 plus faulty addresses.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 3));
          f_xfer(32'($urandom_range(0, 7) * 4), 1'b0);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a;
          int unsigned k;
          idle($urandom_range(0, 3));
          k = $urandom_range(0, 9);
          a = 32'($urandom_range(8, 15) * 4);
          if (k == 0) a = a | 32'h1;
          else if (k == 1) a = a | (32'h1 << (AW + 2 + $urandom_range(0, 19)));
          x_xfer(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end
      end
    join
    idle(3);
    chk("f_queue_empty", 32'(f_q.size()), 32'd0);
    chk("x_queue_empty", 32'(x_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
